// File: rtl/vga_rect_fill_if.sv
// Request/pixel bundle between a fill requester, vga_rect_fill and the frame-buffer writer.
// Pixel handshake: a pixel transfers on a clock edge where plot && ready; while ready is low the
// producer holds plot, x, y and color stable, and it never withdraws plot once raised.
interface vga_rect_fill_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int COLOR_W = 3
);
  logic               start;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [X_W-1:0]     rect_w;
  logic [Y_W-1:0]     rect_h;
  logic [COLOR_W-1:0] color_in;
  logic               ready;
  logic               busy;
  logic               plot;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               done;

  modport slave (
    input  start, x0, y0, rect_w, rect_h, color_in, ready,
    output busy, plot, x, y, color, done
  );

  modport master (
    output start, x0, y0, rect_w, rect_h, color_in, ready,
    input  busy, plot, x, y, color, done
  );
endinterface

// File: rtl/vga_rect_fill.sv
// Row-major rectangle filler for the VGA frame buffer, clipped to the visible screen,
// emitting one pixel per accepted plot/ready cycle.
module vga_rect_fill #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clock,
  input  logic               resetn,
  vga_rect_fill_if.slave     bus,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  state_t             state_q;
  logic [X_W-1:0]     x0_q, w_q, x_q;
  logic [Y_W-1:0]     y0_q, h_q, y_q;
  logic [X_W:0]       x_end_q;
  logic [Y_W:0]       y_end_q;
  logic [COLOR_W-1:0] color_q;
  logic               busy_q, plot_q, done_q;

  logic [X_W:0] x_sum_d, x_end_d, x_inc_d;
  logic [Y_W:0] y_sum_d, y_end_d, y_inc_d;
  logic         degenerate_d;

  // Sums carry one extra bit so a rectangle running past the edge clips instead of wrapping.
  always_comb begin
    x_sum_d      = {1'b0, x0_q} + {1'b0, w_q};
    y_sum_d      = {1'b0, y0_q} + {1'b0, h_q};
    x_end_d      = (x_sum_d > SCR_W) ? SCR_W : x_sum_d;
    y_end_d      = (y_sum_d > SCR_H) ? SCR_H : y_sum_d;
    x_inc_d      = {1'b0, x_q} + (X_W+1)'(1);
    y_inc_d      = {1'b0, y_q} + (Y_W+1)'(1);
    degenerate_d = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x0_q} >= SCR_W) || ({1'b0, y0_q} >= SCR_H);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      x_end_q <= '0;
      y_end_q <= '0;
      color_q <= '0;
      busy_q  <= 1'b0;
      plot_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          plot_q <= 1'b0;
          if (bus.start) begin
            x0_q    <= bus.x0;
            y0_q    <= bus.y0;
            w_q     <= bus.rect_w;
            h_q     <= bus.rect_h;
            color_q <= bus.color_in;
            busy_q  <= 1'b1;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          x_end_q <= x_end_d;
          y_end_q <= y_end_d;
          if (degenerate_d) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            x_q     <= x0_q;
            y_q     <= y0_q;
            plot_q  <= 1'b1;
            state_q <= DRAW;
          end
        end
        DRAW: begin
          if (bus.ready) begin
            if (x_inc_d == x_end_q) begin
              if (y_inc_d == y_end_q) begin
                plot_q  <= 1'b0;
                done_q  <= 1'b1;
                state_q <= DONE;
              end else begin
                x_q <= x0_q;
                y_q <= y_inc_d[Y_W-1:0];
              end
            end else begin
              x_q <= x_inc_d[X_W-1:0];
            end
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.plot  = plot_q;
  assign bus.x     = x_q;
  assign bus.y     = y_q;
  assign bus.color = color_q;
  assign bus.done  = done_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: normal fill, clipping, degenerate requests, stall,
// ignored start while busy and mid-fill reset.
module tb_vga_rect_fill;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOR_W = 3;

  logic clock;
  logic resetn;
  logic [1:0] state_dbg;

  vga_rect_fill_if #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W)) bus ();

  vga_rect_fill #(.X_W(X_W), .Y_W(Y_W), .COLOR_W(COLOR_W), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock   (clock),
    .resetn  (resetn),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard
  logic [X_W+Y_W-1:0] exp_q[$];
  logic [X_W+Y_W-1:0] px_q[$];
  logic [COLOR_W-1:0] fill_color;
  int first_plot, done_cyc, done_cnt, busy_cycles, plot_cycles;
  int color_bad, oob, stall_cycles, frozen_bad, ended;
  logic [X_W-1:0] stall_x;
  logic [Y_W-1:0] stall_y;

  // driver tasks
  task automatic start_fill(input int x0, input int y0, input int w, input int h, input int c);
    @(posedge clock); #1;
    bus.x0       = X_W'(x0);
    bus.y0       = Y_W'(y0);
    bus.rect_w   = X_W'(w);
    bus.rect_h   = Y_W'(h);
    bus.color_in = COLOR_W'(c);
    fill_color   = COLOR_W'(c);
    bus.start    = 1'b1;
    @(posedge clock); #1;
    bus.start    = 1'b0;
  endtask

  // Cycle 1 is the first cycle after the edge that sampled start.
  task automatic collect(input int budget, input int stall_idx, input int stall_len,
                         input int extra_start_cyc);
    int stall_rem;
    int n_acc;
    stall_rem = stall_len;
    n_acc = 0;
    px_q.delete();
    first_plot = -1; done_cyc = -1; done_cnt = 0; busy_cycles = 0; plot_cycles = 0;
    color_bad = 0; oob = 0; stall_cycles = 0; frozen_bad = 0; ended = 0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clock);
      bus.start = (cyc == extra_start_cyc);
      if (bus.plot && n_acc == stall_idx && stall_rem > 0) begin
        bus.ready = 1'b0;
        stall_rem--;
        if (stall_cycles == 0) begin
          stall_x = bus.x;
          stall_y = bus.y;
        end else if (bus.x !== stall_x || bus.y !== stall_y) begin
          frozen_bad++;
        end
        stall_cycles++;
      end else begin
        bus.ready = 1'b1;
      end
      if (bus.plot) begin
        plot_cycles++;
        if (first_plot < 0) first_plot = cyc;
      end
      if (bus.plot && bus.ready) begin
        px_q.push_back({bus.x, bus.y});
        n_acc++;
        if (bus.color !== fill_color) color_bad++;
        if (bus.x >= 8'd160 || bus.y >= 7'd120) oob++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.busy) busy_cycles++;
      bus.color_in = ~bus.color_in;
      if (!bus.busy && cyc > 1) begin
        ended = 1;
        break;
      end
    end
    bus.start = 1'b0;
    bus.ready = 1'b1;
  endtask

  task automatic build_exp(input int x0, input int y0, input int xe, input int ye);
    exp_q.delete();
    for (int yy = y0; yy < ye; yy++)
      for (int xx = x0; xx < xe; xx++)
        exp_q.push_back({X_W'(xx), Y_W'(yy)});
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    bus.start = 1'b0; bus.ready = 1'b1;
    bus.x0 = '0; bus.y0 = '0; bus.rect_w = '0; bus.rect_h = '0; bus.color_in = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_checks++; if (bus.plot !== 1'b0) begin n_fail++; $display("FAIL reset_plot: got %0b want 0", bus.plot); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    n_checks++; if (bus.x !== 8'd0) begin n_fail++; $display("FAIL reset_x: got %0d want 0", bus.x); end
    n_checks++; if (bus.y !== 7'd0) begin n_fail++; $display("FAIL reset_y: got %0d want 0", bus.y); end
    n_checks++; if (bus.color !== 3'd0) begin n_fail++; $display("FAIL reset_color: got %0d want 0", bus.color); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    resetn = 1'b1;
  endtask

  task automatic test_basic_fill;
    start_fill(10, 20, 3, 2, 6);
    collect(60, -1, 0, 0);
    build_exp(10, 20, 13, 22);
    n_checks++; if (ended !== 1) begin n_fail++; $display("FAIL basic_timeout: got %0d want 1", ended); end
    n_checks++; if (px_q.size() !== 6) begin n_fail++; $display("FAIL basic_count: got %0d want 6", px_q.size()); end
    for (int i = 0; i < 6 && i < px_q.size(); i++) begin
      n_checks++;
      if (px_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL basic_pixel%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 px_q[i][X_W+Y_W-1:Y_W], px_q[i][Y_W-1:0], exp_q[i][X_W+Y_W-1:Y_W], exp_q[i][Y_W-1:0]);
      end
    end
    n_checks++; if (first_plot !== 2) begin n_fail++; $display("FAIL basic_first_plot: got %0d want 2", first_plot); end
    n_checks++; if (done_cyc !== 8) begin n_fail++; $display("FAIL basic_done_cyc: got %0d want 8", done_cyc); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (busy_cycles !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", busy_cycles); end
    n_checks++; if (color_bad !== 0) begin n_fail++; $display("FAIL basic_color: got %0d bad want 0", color_bad); end
  endtask

  task automatic test_clip;
    start_fill(158, 118, 5, 5, 3);
    collect(60, -1, 0, 0);
    build_exp(158, 118, 160, 120);
    n_checks++; if (px_q.size() !== 4) begin n_fail++; $display("FAIL clip_count: got %0d want 4", px_q.size()); end
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      n_checks++;
      if (px_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL clip_pixel%0d: got (%0d,%0d) want (%0d,%0d)", i,
                 px_q[i][X_W+Y_W-1:Y_W], px_q[i][Y_W-1:0], exp_q[i][X_W+Y_W-1:Y_W], exp_q[i][Y_W-1:0]);
      end
    end
    n_checks++; if (oob !== 0) begin n_fail++; $display("FAIL clip_oob: got %0d want 0", oob); end
    n_checks++; if (done_cyc !== 6) begin n_fail++; $display("FAIL clip_done_cyc: got %0d want 6", done_cyc); end
  endtask

  task automatic test_degenerate;
    start_fill(10, 20, 0, 2, 1);
    collect(20, -1, 0, 0);
    n_checks++; if (plot_cycles !== 0) begin n_fail++; $display("FAIL degen_w0_plots: got %0d want 0", plot_cycles); end
    n_checks++; if (done_cyc !== 2) begin n_fail++; $display("FAIL degen_w0_done_cyc: got %0d want 2", done_cyc); end
    n_checks++; if (busy_cycles !== 2) begin n_fail++; $display("FAIL degen_w0_busy: got %0d want 2", busy_cycles); end
    start_fill(170, 20, 3, 2, 1);
    collect(20, -1, 0, 0);
    n_checks++; if (plot_cycles !== 0) begin n_fail++; $display("FAIL degen_x170_plots: got %0d want 0", plot_cycles); end
    n_checks++; if (done_cyc !== 2) begin n_fail++; $display("FAIL degen_x170_done_cyc: got %0d want 2", done_cyc); end
    n_checks++; if (busy_cycles !== 2) begin n_fail++; $display("FAIL degen_x170_busy: got %0d want 2", busy_cycles); end
  endtask

  task automatic test_stall;
    start_fill(30, 40, 4, 1, 5);
    collect(60, 1, 3, 0);
    build_exp(30, 40, 34, 41);
    n_checks++; if (px_q.size() !== 4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", px_q.size()); end
    for (int i = 0; i < 4 && i < px_q.size(); i++) begin
      n_checks++;
      if (px_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_pixel%0d: got x=%0d want x=%0d", i, px_q[i][X_W+Y_W-1:Y_W], exp_q[i][X_W+Y_W-1:Y_W]);
      end
    end
    n_checks++; if (stall_cycles !== 3) begin n_fail++; $display("FAIL stall_cycles: got %0d want 3", stall_cycles); end
    n_checks++; if (stall_x !== 8'd31 || stall_y !== 7'd40) begin n_fail++; $display("FAIL stall_pos: got (%0d,%0d) want (31,40)", stall_x, stall_y); end
    n_checks++; if (frozen_bad !== 0) begin n_fail++; $display("FAIL stall_frozen: got %0d moves want 0", frozen_bad); end
    n_checks++; if (plot_cycles !== 7) begin n_fail++; $display("FAIL stall_plot_cycles: got %0d want 7", plot_cycles); end
    n_checks++; if (color_bad !== 0) begin n_fail++; $display("FAIL stall_color: got %0d bad want 0", color_bad); end
    n_checks++; if (done_cyc !== 9) begin n_fail++; $display("FAIL stall_done_cyc: got %0d want 9", done_cyc); end
  endtask

  task automatic test_start_ignore_and_reset;
    int late_busy;
    int late_done;
    int late_plot;
    start_fill(50, 60, 3, 2, 2);
    collect(60, -1, 0, 4);
    late_busy = 0;
    repeat (4) begin
      @(negedge clock);
      if (bus.busy) late_busy++;
    end
    n_checks++; if (px_q.size() !== 6) begin n_fail++; $display("FAIL ignore_count: got %0d want 6", px_q.size()); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_cnt: got %0d want 1", done_cnt); end
    n_checks++; if (late_busy !== 0) begin n_fail++; $display("FAIL ignore_queued: got %0d busy cycles want 0", late_busy); end

    start_fill(0, 0, 20, 10, 7);
    repeat (5) @(negedge clock);
    n_checks++; if (bus.plot !== 1'b1) begin n_fail++; $display("FAIL rst_pre_plot: got %0b want 1", bus.plot); end
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b want 0", bus.busy); end
    n_checks++; if (bus.plot !== 1'b0) begin n_fail++; $display("FAIL rst_plot: got %0b want 0", bus.plot); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b want 0", bus.done); end
    n_checks++; if (bus.x !== 8'd0 || bus.y !== 7'd0) begin n_fail++; $display("FAIL rst_xy: got (%0d,%0d) want (0,0)", bus.x, bus.y); end
    n_checks++; if (bus.color !== 3'd0) begin n_fail++; $display("FAIL rst_color: got %0d want 0", bus.color); end
    late_done = 0; late_plot = 0; late_busy = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.done) late_done++;
      if (bus.plot) late_plot++;
      if (bus.busy) late_busy++;
    end
    n_checks++; if (late_done !== 0) begin n_fail++; $display("FAIL rst_no_done: got %0d want 0", late_done); end
    n_checks++; if (late_plot + late_busy !== 0) begin n_fail++; $display("FAIL rst_quiet: got %0d active cycles want 0", late_plot + late_busy); end

    start_fill(5, 5, 2, 1, 4);
    collect(30, -1, 0, 0);
    build_exp(5, 5, 7, 6);
    n_checks++; if (px_q.size() !== 2) begin n_fail++; $display("FAIL fresh_count: got %0d want 2", px_q.size()); end
    n_checks++; if (px_q.size() == 2 && px_q[1] !== exp_q[1]) begin n_fail++; $display("FAIL fresh_last_x: got %0d want 6", px_q[1][X_W+Y_W-1:Y_W]); end
    n_checks++; if (done_cnt !== 1) begin n_fail++; $display("FAIL fresh_done: got %0d want 1", done_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_clip();
    test_degenerate();
    test_stall();
    test_start_ignore_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
